addr_reg_seq: RTL and testbench

- Parametrised successor to the combined M1/M2 address register.
- Holds a 2*HALF_W-bit address built from independently loadable high and low halves.
- Can also load the full address word from the address bus, or increment itself with relay-style settle latency.
- Drives the address bus on select. Sits in the register unit between the data bus (8-bit halves), the address bus and the control sequencer.

---
 rtl/reg_unit_pkg.sv | 17 +
 rtl/inc_timer.sv | 38 +++
 rtl/addr_reg_seq.sv | 114 +++++++++++
 tb/tb_addr_reg_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_unit_pkg.sv
// Types and constants shared by the register-unit address registers
// (M1/M2 address register, PC and XY incrementers).
package reg_unit_pkg;

  localparam int HALF_W_DEF  = 8;
  localparam int AW_DEF      = 2 * HALF_W_DEF;
  localparam int INC_LAT_DEF = 3;

  typedef logic [AW_DEF-1:0]     addr_t;
  typedef logic [HALF_W_DEF-1:0] half_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    INC  = 1'b1
  } state_e;

endpackage

// File: rtl/inc_timer.sv
// Down-counter that models relay incrementer settle time: start arms it,
// busy holds for LAT cycles, expire marks the committing edge, done follows it.
module inc_timer #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic expire,
  output logic done
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [CW-1:0] cnt;

  assign expire = busy && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= expire;
      if (start) begin
        busy <= 1'b1;
        cnt  <= CW'(LAT - 1);
      end else if (expire) begin
        busy <= 1'b0;
      end else if (busy) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/addr_reg_seq.sv
// Combined M1/M2 address register: half loads from the data bus, full load
// from the address bus, slow increment, and select-gated address bus drive.
module addr_reg_seq
  import reg_unit_pkg::*;
#(
  parameter int                      HALF_W    = 8,
  parameter int                      INC_LAT   = INC_LAT_DEF,
  parameter logic [2*HALF_W-1:0]     RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [HALF_W-1:0]     data_in,
  input  logic                  ld_hi,
  input  logic                  ld_lo,
  input  logic [2*HALF_W-1:0]   addr_in,
  input  logic                  ld_full,
  input  logic                  inc_req,
  input  logic                  sel,
  input  logic                  clr_err,
  output logic [2*HALF_W-1:0]   addr_out,
  output logic                  addr_oe,
  output logic [HALF_W-1:0]     hi_out,
  output logic [HALF_W-1:0]     lo_out,
  output logic                  busy,
  output logic                  inc_done,
  output logic                  conflict,
  output logic                  led_ld,
  output logic                  led_sel
);

  localparam int AW = 2 * HALF_W;

  state_e        state, state_nx;
  logic [AW-1:0] content;
  logic          timer_start, timer_expire;
  logic          take_full, take_hi, take_lo, conflict_set;

  inc_timer #(.LAT(INC_LAT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (timer_start),
    .busy   (busy),
    .expire (timer_expire),
    .done   (inc_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Command decode: full load beats half loads beats increment; losers flag conflict.
  always_comb begin
    state_nx     = state;
    timer_start  = 1'b0;
    take_full    = 1'b0;
    take_hi      = 1'b0;
    take_lo      = 1'b0;
    conflict_set = 1'b0;
    case (state)
      IDLE: begin
        if (ld_full) begin
          take_full    = 1'b1;
          conflict_set = ld_hi | ld_lo | inc_req;
        end else if (ld_hi || ld_lo) begin
          take_hi      = ld_hi;
          take_lo      = ld_lo;
          conflict_set = inc_req;
        end else if (inc_req) begin
          timer_start = 1'b1;
          state_nx    = INC;
        end
      end
      INC: begin
        conflict_set = ld_hi | ld_lo | ld_full | inc_req;
        if (timer_expire) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      content <= RESET_VAL;
    end else if (take_full) begin
      content <= addr_in;
    end else if (state == INC && timer_expire) begin
      content <= content + AW'(1);
    end else begin
      if (take_hi) content[AW-1:HALF_W]   <= data_in;
      if (take_lo) content[HALF_W-1:0]    <= data_in;
    end
  end

  // Set has priority over clear so a coincident fault is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            conflict <= 1'b0;
    else if (conflict_set) conflict <= 1'b1;
    else if (clr_err)      conflict <= 1'b0;
  end

  assign addr_oe  = sel;
  assign addr_out = sel ? content : '0;
  assign hi_out   = content[AW-1:HALF_W];
  assign lo_out   = content[HALF_W-1:0];
  assign led_ld   = ld_hi | ld_lo | ld_full;
  assign led_sel  = sel;

`ifndef SYNTHESIS
  a_no_self_load: assert property (@(posedge clk) disable iff (!rst_n) !(sel && ld_full))
    else $warning("addr_reg_seq: sel and ld_full in the same cycle (bus self-load)");
`endif

endmodule

// File: tb/tb_addr_reg_seq.sv
// Directed bench for addr_reg_seq with HALF_W=8, INC_LAT=3, RESET_VAL=0.
module tb_addr_reg_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        ld_hi, ld_lo, ld_full, inc_req, sel, clr_err;
  logic [15:0] addr_in;
  logic [15:0] addr_out;
  logic        addr_oe;
  logic [7:0]  hi_out, lo_out;
  logic        busy, inc_done, conflict, led_ld, led_sel;

  int n_cmp = 0;
  int n_err = 0;

  addr_reg_seq #(.HALF_W(8), .INC_LAT(3), .RESET_VAL(16'h0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .ld_hi    (ld_hi),
    .ld_lo    (ld_lo),
    .addr_in  (addr_in),
    .ld_full  (ld_full),
    .inc_req  (inc_req),
    .sel      (sel),
    .clr_err  (clr_err),
    .addr_out (addr_out),
    .addr_oe  (addr_oe),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .inc_done (inc_done),
    .conflict (conflict),
    .led_ld   (led_ld),
    .led_sel  (led_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] content();
    return {hi_out, lo_out};
  endfunction

  task automatic idle_inputs();
    data_in = 8'h00; addr_in = 16'h0000;
    ld_hi = 1'b0; ld_lo = 1'b0; ld_full = 1'b0;
    inc_req = 1'b0; sel = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_content", content(), 16'h0000);
    chk("rst_busy", busy, 1'b0);

    // Load something, then reset asynchronously mid-cycle
    ld_full = 1'b1; addr_in = 16'hA5A5;
    tick();
    ld_full = 1'b0;
    chk("pre_rst_content", content(), 16'hA5A5);
    ld_hi = 1'b1; inc_req = 1'b1; data_in = 8'h11;
    tick();
    chk("pre_rst_conflict", conflict, 1'b1);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_content", content(), 16'h0000);
    chk("async_rst_conflict", conflict, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_oe", addr_oe, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Half loads then select
    ld_hi = 1'b1; data_in = 8'h12;
    #1 chk("led_ld", led_ld, 1'b1);
    tick();
    ld_hi = 1'b0; ld_lo = 1'b1; data_in = 8'h34;
    tick();
    ld_lo = 1'b0; sel = 1'b1;
    #1;
    chk("sel_addr_out", addr_out, 16'h1234);
    chk("sel_oe", addr_oe, 1'b1);
    chk("sel_led", led_sel, 1'b1);
    chk("hi_out", hi_out, 8'h12);
    chk("lo_out", lo_out, 8'h34);
    chk("half_no_conflict", conflict, 1'b0);

    // Select together with a half load shows old content first
    ld_lo = 1'b1; data_in = 8'h56;
    #1 chk("sel_ld_old", addr_out, 16'h1234);
    tick();
    ld_lo = 1'b0;
    chk("sel_ld_new", addr_out, 16'h1256);
    sel = 1'b0;
    #1 chk("unsel_out", addr_out, 16'h0000);

    // Both halves with the same byte
    ld_hi = 1'b1; ld_lo = 1'b1; data_in = 8'h5A;
    tick();
    ld_hi = 1'b0; ld_lo = 1'b0;
    chk("both_halves", content(), 16'h5A5A);

    // Increment latency from 0x00FF
    ld_full = 1'b1; addr_in = 16'h00FF;
    tick();
    ld_full = 1'b0; inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    chk("inc_busy1", busy, 1'b1);
    chk("inc_done1", inc_done, 1'b0);
    sel = 1'b1;
    #1 chk("inc_sel_old", addr_out, 16'h00FF);
    sel = 1'b0;
    tick();
    chk("inc_busy2", busy, 1'b1);
    tick();
    chk("inc_busy3", busy, 1'b1);
    chk("inc_mid_content", content(), 16'h00FF);
    tick();
    chk("inc_busy_end", busy, 1'b0);
    chk("inc_content", content(), 16'h0100);
    chk("inc_done_pulse", inc_done, 1'b1);
    tick();
    chk("inc_done_clear", inc_done, 1'b0);
    chk("inc_no_conflict", conflict, 1'b0);

    // Wrap from all-ones
    ld_full = 1'b1; addr_in = 16'hFFFF;
    tick();
    ld_full = 1'b0; inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    tick(); tick(); tick();
    chk("wrap_content", content(), 16'h0000);
    chk("wrap_done", inc_done, 1'b1);
    chk("wrap_conflict", conflict, 1'b0);
    tick();

    // Full load with increment request
    ld_full = 1'b1; addr_in = 16'hBEEF; inc_req = 1'b1;
    tick();
    ld_full = 1'b0; inc_req = 1'b0;
    chk("full_inc_content", content(), 16'hBEEF);
    chk("full_inc_conflict", conflict, 1'b1);
    chk("full_inc_busy", busy, 1'b0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_conflict", conflict, 1'b0);

    // Half load with increment plus clear in same cycle: set wins
    ld_hi = 1'b1; data_in = 8'h77; inc_req = 1'b1; clr_err = 1'b1;
    tick();
    idle_inputs();
    chk("set_wins", conflict, 1'b1);
    chk("set_wins_content", content(), 16'h77EF);
    chk("set_wins_busy", busy, 1'b0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_again", conflict, 1'b0);

    // Load during busy is ignored
    inc_req = 1'b1;
    tick();
    inc_req = 1'b0; ld_lo = 1'b1; data_in = 8'h00;
    tick();
    ld_lo = 1'b0;
    chk("busy_ld_conflict", conflict, 1'b1);
    chk("busy_ld_ignored", content(), 16'h77EF);
    tick(); tick();
    chk("busy_ld_inc", content(), 16'h77F0);
    chk("busy_ld_done", inc_done, 1'b1);
    chk("busy_ld_sticky", conflict, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("busy_ld_clr", conflict, 1'b0);

    // Reset during increment abandons it
    ld_full = 1'b1; addr_in = 16'h0010;
    tick();
    ld_full = 1'b0; inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midinc_rst_content", content(), 16'h0000);
    chk("midinc_rst_busy", busy, 1'b0);
    tick();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midinc_no_done", inc_done, 1'b0);
    end
    chk("midinc_final", content(), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
